// File: rtl/alu_issue_seq.sv
// ---------------------------------------------------------------------------
// alu_issue_seq
//
// Issue controller that drives the combinational datapath ALU. It accepts one
// R-type operation at a time, decodes funct into the ALU control line, holds
// the ALU inputs steady for EXEC_CYCLES cycles, captures the result and flags,
// and then offers the captured response to writeback.
//
// Parameters
//   EXEC_CYCLES  cycles the ALU inputs are held before capture (1..15)
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_funct            MIPS R-type funct
//   req_shamt            shift amount
//   req_rs, req_rt       operands A and B
//   req_tag              opaque tag echoed on the response
//   alu_a, alu_b         ALU operands (held between operations)
//   alu_sham             ALU shift amount
//   alu_gin              ALU control line
//   alu_sum, alu_zout    ALU result and zero flag
//   rsp_valid/rsp_ready  response handshake
//   rsp_result           captured result
//   rsp_zero, rsp_neg    captured zero flag and alu_sum[31]
//   rsp_illegal          funct was not a supported operation
//   rsp_tag              tag of the request that produced the response
// ---------------------------------------------------------------------------
module alu_issue_seq #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [4:0]  req_shamt,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  input  logic [3:0]  req_tag,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_sham,
  output logic [2:0]  alu_gin,
  input  logic [31:0] alu_sum,
  input  logic        alu_zout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_neg,
  output logic        rsp_illegal,
  output logic [3:0]  rsp_tag
);

  // The counter runs down from EXEC_CYCLES-1; capture happens on the cycle it
  // is already zero, which places capture exactly EXEC_CYCLES edges after the
  // accept.
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [3:0] tag_reg;

  logic [2:0] dec_gin;
  logic       dec_legal;

  logic       load_op;
  logic       load_illegal;
  logic       capture;

  // -------------------------------------------------------------------------
  // funct -> ALU control line
  // -------------------------------------------------------------------------
  always_comb begin
    dec_gin   = 3'b000;
    dec_legal = 1'b1;
    case (req_funct)
      6'b100000: dec_gin = 3'b010;  // add
      6'b100010: dec_gin = 3'b110;  // sub
      6'b100100: dec_gin = 3'b000;  // and
      6'b100101: dec_gin = 3'b001;  // or
      6'b100110: dec_gin = 3'b011;  // xor
      6'b101010: dec_gin = 3'b111;  // slt
      6'b000010: dec_gin = 3'b100;  // srl
      default:   dec_legal = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register and settle counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and control decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    load_op      = 1'b0;
    load_illegal = 1'b0;
    capture      = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (dec_legal) begin
            load_op    = 1'b1;
            cnt_next   = CNT_LOAD;
            state_next = EXEC;
          end else begin
            // Nothing to compute: the response is formed immediately and the
            // ALU inputs keep their previous values.
            load_illegal = 1'b1;
            state_next   = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        // Returning to IDLE (not straight to accept) keeps requests strictly
        // serialized: nothing is accepted on the completing cycle.
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // ALU input registers: only loaded on a legal accept so the ALU sees no
  // toggling between operations.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= 32'd0;
      alu_b    <= 32'd0;
      alu_sham <= 5'd0;
      alu_gin  <= 3'b000;
      tag_reg  <= 4'd0;
    end else if (load_op) begin
      alu_a    <= req_rs;
      alu_b    <= req_rt;
      alu_sham <= req_shamt;
      alu_gin  <= dec_gin;
      tag_reg  <= req_tag;
    end
  end

  // -------------------------------------------------------------------------
  // Response registers: written only at capture (legal) or accept (illegal),
  // and left untouched after the response is consumed.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result  <= 32'd0;
      rsp_zero    <= 1'b0;
      rsp_neg     <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_tag     <= 4'd0;
    end else if (capture) begin
      rsp_result  <= alu_sum;
      rsp_zero    <= alu_zout;
      rsp_neg     <= alu_sum[31];
      rsp_illegal <= 1'b0;
      rsp_tag     <= tag_reg;
    end else if (load_illegal) begin
      rsp_result  <= 32'd0;
      rsp_zero    <= 1'b0;
      rsp_neg     <= 1'b0;
      rsp_illegal <= 1'b1;
      rsp_tag     <= req_tag;
    end
  end

endmodule
